// File: rtl/led_pwm_bank.sv
// led_pwm_bank: N-channel PWM engine fed by framed duty updates from an SPI byte stream.
// Frames are assembled in a staging buffer. A completed frame is copied to shadow.
// Shadow is moved to active only at a PWM period wrap, so a duty never changes mid-period.
// Optional build macro LED_FADE_EN: active walks one LSB per wrap toward shadow.
//
// Receive FSM states:
//   state   | meaning
//   S_IDLE  | cs high, or waiting for the 0xA5 header byte
//   S_LOAD  | collecting channel bytes, MSB first, into staging
//   S_DRAIN | frame finished or rejected; ignore bytes until cs rises
module led_pwm_bank #(
   parameter int CHANNELS = 4,
   parameter int DUTY_W   = 8,
   parameter int PRESC    = 1
) (
   input  logic                clk12,
   input  logic                reset,
   input  logic                cs,
   input  logic                rx_valid,
   input  logic [7:0]          rx_data,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                commit,
   output logic                frame_err
);
   localparam int BPC    = (DUTY_W + 7) / 8;
   localparam int NBYTES = CHANNELS * BPC;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [7:0]        HEADER   = 8'hA5;
   localparam logic [DUTY_W-1:0] CNT_MAX  = DUTY_W'((1 << DUTY_W) - 2);
   localparam logic [15:0]       PRESC_LD = 16'(PRESC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t            r_state;
   logic [IDX_W-1:0]  r_idx;
   logic [7:0]        r_stage [NBYTES];
   logic              r_frame_err;
   logic [DUTY_W-1:0] r_shadow [CHANNELS];
   logic [DUTY_W-1:0] r_active [CHANNELS];
   logic              r_pending;
   logic [DUTY_W-1:0] r_cnt;
   logic [15:0]       r_presc;
   logic              r_commit;
   logic [CHANNELS-1:0] r_pwm;

   logic [7:0]        w_byte_next [NBYTES];
   logic [DUTY_W-1:0] w_duty [CHANNELS];
   logic [DUTY_W-1:0] w_act_next [CHANNELS];
   logic              w_all_done;
   logic [CHANNELS-1:0] w_pwm;
   logic              w_last;
   logic              w_frame_done;

   assign w_last       = (r_idx == IDX_W'(NBYTES - 1));
   assign w_frame_done = !cs && rx_valid && (r_state == S_LOAD) && w_last;

   // Staging with the incoming byte merged in, and the per-channel duties it spells out
   always_comb begin
      logic [DUTY_W-1:0] w_acc;
      for (int b = 0; b < NBYTES; b++)
         w_byte_next[b] = (r_idx == IDX_W'(b)) ? rx_data : r_stage[b];
      for (int c = 0; c < CHANNELS; c++) begin
         w_acc = '0;
         // shifting MSB-first bytes through a DUTY_W-wide register drops the unused high bits
         for (int b = 0; b < BPC; b++)
            w_acc = DUTY_W'({w_acc, w_byte_next[c*BPC + b]});
         w_duty[c] = w_acc;
      end
   end

   // Next active value at a wrap: single jump, or one LSB step when fading
   always_comb begin
      w_all_done = 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
`ifdef LED_FADE_EN
         if (r_active[c] < r_shadow[c])
            w_act_next[c] = r_active[c] + DUTY_W'(1);
         else if (r_active[c] > r_shadow[c])
            w_act_next[c] = r_active[c] - DUTY_W'(1);
         else
            w_act_next[c] = r_active[c];
         if (w_act_next[c] != r_shadow[c])
            w_all_done = 1'b0;
`else
         w_act_next[c] = r_shadow[c];
`endif
      end
   end

   // Duty comparators
   always_comb begin
      w_pwm = '0;
      for (int c = 0; c < CHANNELS; c++)
         w_pwm[c] = (r_cnt < r_active[c]);
   end

   // Receive FSM: header check, bytewise staging, abort on cs rise
   always_ff @(posedge clk12 or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_frame_err <= 1'b0;
         for (int b = 0; b < NBYTES; b++)
            r_stage[b] <= '0;
      end else begin
         r_frame_err <= 1'b0;
         if (cs) begin
            if (r_state == S_LOAD)
               r_frame_err <= 1'b1;
            r_state <= S_IDLE;
         end else if (rx_valid) begin
            case (r_state)
               S_IDLE: begin
                  if (rx_data == HEADER) begin
                     r_state <= S_LOAD;
                     r_idx   <= '0;
                  end else begin
                     r_state     <= S_DRAIN;
                     r_frame_err <= 1'b1;
                  end
               end
               S_LOAD: begin
                  for (int b = 0; b < NBYTES; b++)
                     r_stage[b] <= w_byte_next[b];
                  if (w_last)
                     r_state <= S_DRAIN;
                  else
                     r_idx <= r_idx + IDX_W'(1);
               end
               default: ;
            endcase
         end
      end
   end

   // Prescaler, period counter, shadow/active transfer and registered outputs
   always_ff @(posedge clk12 or negedge reset) begin
      if (!reset) begin
         r_pending <= 1'b0;
         r_cnt     <= '0;
         r_presc   <= '0;
         r_commit  <= 1'b0;
         r_pwm     <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            r_shadow[c] <= '0;
            r_active[c] <= '0;
         end
      end else begin
         r_commit <= 1'b0;
         r_pwm    <= w_pwm;
         if (r_presc == 16'd0) begin
            r_presc <= PRESC_LD;
            if (r_cnt == CNT_MAX) begin
               r_cnt <= '0;
               if (r_pending) begin
                  for (int c = 0; c < CHANNELS; c++)
                     r_active[c] <= w_act_next[c];
                  if (w_all_done) begin
                     r_pending <= 1'b0;
                     r_commit  <= 1'b1;
                  end
               end
            end else begin
               r_cnt <= r_cnt + DUTY_W'(1);
            end
         end else begin
            r_presc <= r_presc - 16'd1;
         end
         // a frame landing on the wrap cycle keeps pending set for the next wrap
         if (w_frame_done) begin
            r_pending <= 1'b1;
            for (int c = 0; c < CHANNELS; c++)
               r_shadow[c] <= w_duty[c];
         end
      end
   end

   assign pwm_out   = r_pwm;
   assign commit    = r_commit;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_led_pwm_bank.sv
// Bench for led_pwm_bank: two instances (4ch/8bit/presc 1 and 2ch/10bit/presc 2).
// Expected commit edges come from closed-form wrap arithmetic; expected high counts
// come from the duties the bench itself sent.
module tb_led_pwm_bank;
   localparam int PER_A = 255;
   localparam int P_A   = 1;
   localparam int PER_B = 1023;
   localparam int P_B   = 2;

   logic       clk12 = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] cs_v  = 2'b00;
   logic [1:0] rxv_v = 2'b00;
   logic [7:0] rxd_a = 8'h00;
   logic [7:0] rxd_b = 8'h00;
   logic [1:0] commit_v;
   logic [1:0] ferr_v;
   logic [3:0] pwm_a;
   logic [1:0] pwm_b;

   int errors = 0;
   int checks = 0;
   int edge_cnt;
   int n_commit [2] = '{0, 0};
   int n_ferr   [2] = '{0, 0};
   int m_shadow [2][4];
   int m_active [2][4];

   always #5 clk12 = ~clk12;

   led_pwm_bank #(.CHANNELS(4), .DUTY_W(8), .PRESC(1)) u_dut_a (
      .clk12(clk12), .reset(reset), .cs(cs_v[0]), .rx_valid(rxv_v[0]), .rx_data(rxd_a),
      .pwm_out(pwm_a), .commit(commit_v[0]), .frame_err(ferr_v[0]));

   led_pwm_bank #(.CHANNELS(2), .DUTY_W(10), .PRESC(2)) u_dut_b (
      .clk12(clk12), .reset(reset), .cs(cs_v[1]), .rx_valid(rxv_v[1]), .rx_data(rxd_b),
      .pwm_out(pwm_b), .commit(commit_v[1]), .frame_err(ferr_v[1]));

   always @(posedge clk12 or negedge reset)
      if (!reset) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;

   always @(posedge clk12) begin
      #1;
      for (int d = 0; d < 2; d++) begin
         if (commit_v[d] === 1'b1) n_commit[d]++;
         if (ferr_v[d] === 1'b1)   n_ferr[d]++;
      end
   end

   function automatic int per_of(int d);   return (d == 0) ? PER_A : PER_B; endfunction
   function automatic int presc_of(int d); return (d == 0) ? P_A : P_B;     endfunction
   function automatic int nch(int d);      return (d == 0) ? 4 : 2;         endfunction

   function automatic bit is_wrap(int d, int e);
      return (e % presc_of(d) == 0) && ((e / presc_of(d)) % per_of(d) == per_of(d) - 1);
   endfunction

   // ticks happen at edges P*j; tick j is a wrap when j mod PERIOD == PERIOD-1
   function automatic int next_wrap_after(int d, int e);
      int j0;
      j0 = e / presc_of(d) + 1;
      return presc_of(d) * (j0 + (per_of(d) - 1 - (j0 % per_of(d))));
   endfunction

   function automatic int pwm_bit(int d, int c);
      if (d == 0) return int'(pwm_a[c[1:0]]);
      return int'(pwm_b[c[0]]);
   endfunction

   task automatic chk(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk12);
   endtask

   task automatic drive(int d, logic v, logic [7:0] b);
      rxv_v[d] = v;
      if (d == 0) rxd_a = b;
      else        rxd_b = b;
   endtask

   task automatic send_byte(int d, logic [7:0] b);
      drive(d, 1'b1, b);
      tick();
      drive(d, 1'b0, 8'h00);
   endtask

   task automatic send_frame(int d, int duty [4], int junk, output int last_e);
      logic [9:0] dv;
      cs_v[d] = 1'b0;
      send_byte(d, 8'hA5);
      for (int c = 0; c < nch(d); c++) begin
         dv = 10'(duty[c]);
         if (d == 0) begin
            send_byte(d, dv[7:0]);
         end else begin
            send_byte(d, {6'(junk), dv[9:8]});
            send_byte(d, dv[7:0]);
         end
         m_shadow[d][c] = duty[c];
      end
      last_e  = edge_cnt - 1;
      cs_v[d] = 1'b1;
   endtask

   task automatic wait_commit(int d, int budget, output int c_edge);
      c_edge = -1;
      for (int i = 0; i < budget; i++) begin
         if (commit_v[d] === 1'b1) begin
            c_edge = edge_cnt - 1;
            return;
         end
         tick();
      end
   endtask

   task automatic measure(int d, output int hc [4]);
      hc = '{0, 0, 0, 0};
      repeat (per_of(d) * presc_of(d)) begin
         tick();
         for (int c = 0; c < nch(d); c++) hc[c] += pwm_bit(d, c);
      end
   endtask

   task automatic check_highs(int d, string tag);
      int hc [4];
      measure(d, hc);
      for (int c = 0; c < nch(d); c++)
         chk($sformatf("%s_high_ch%0d", tag, c), hc[c], m_active[d][c] * presc_of(d));
   endtask

   task automatic frame_and_check(int d, int duty [4], int junk, string tag);
      int le, ce;
      send_frame(d, duty, junk, le);
      wait_commit(d, 2 * per_of(d) * presc_of(d) + 8, ce);
      chk({tag, "_commit_edge"}, ce, next_wrap_after(d, le));
      for (int c = 0; c < nch(d); c++) m_active[d][c] = m_shadow[d][c];
      check_highs(d, tag);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int duty [4];
      int hc [4];
      int f0, c0, le, ce, w, highs;
      for (int d = 0; d < 2; d++)
         for (int c = 0; c < 4; c++) begin
            m_shadow[d][c] = 0;
            m_active[d][c] = 0;
         end

      // reset held with cs low and rx_valid toggling
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("reset_outputs", int'({pwm_a, pwm_b, commit_v, ferr_v}), 0);
         rxv_v = ~rxv_v;
         rxd_a = 8'($urandom);
         rxd_b = 8'hA5;
      end
      rxv_v = 2'b00;
      cs_v  = 2'b11;
      reset = 1'b1;

      highs = 0;
      repeat (300) begin
         tick();
         highs += int'($countones({pwm_a, pwm_b}));
      end
      chk("idle_pwm_highs", highs, 0);
      chk("idle_commit_a", n_commit[0], 0);
      chk("idle_commit_b", n_commit[1], 0);
      chk("idle_ferr", n_ferr[0] + n_ferr[1], 0);

      duty = '{64, 128, 192, 255};
      frame_and_check(0, duty, 0, "basic");

      for (int it = 0; it < 5; it++) begin
         if (it == 0) duty = '{0, 1, 254, 255};
         else for (int c = 0; c < 4; c++) duty[c] = int'($urandom_range(255, 0));
         tick();
         frame_and_check(0, duty, 0, $sformatf("rand_a%0d", it));
      end

      // abort inside LOAD
      f0 = n_ferr[0]; c0 = n_commit[0];
      cs_v[0] = 1'b0;
      send_byte(0, 8'hA5); send_byte(0, 8'h40); send_byte(0, 8'h80);
      cs_v[0] = 1'b1;
      repeat (3) tick();
      chk("abort_ferr", n_ferr[0] - f0, 1);
      check_highs(0, "abort");
      chk("abort_commit", n_commit[0] - c0, 0);

      // bad header, remaining bytes drained
      f0 = n_ferr[0]; c0 = n_commit[0];
      cs_v[0] = 1'b0;
      send_byte(0, 8'h12);
      for (int i = 0; i < 4; i++) send_byte(0, 8'h00);
      cs_v[0] = 1'b1;
      repeat (3) tick();
      chk("badhdr_ferr", n_ferr[0] - f0, 1);
      check_highs(0, "badhdr");
      chk("badhdr_commit", n_commit[0] - c0, 0);

      // cs rise coincident with the final byte: byte discarded
      f0 = n_ferr[0]; c0 = n_commit[0];
      cs_v[0] = 1'b0;
      send_byte(0, 8'hA5); send_byte(0, 8'h11); send_byte(0, 8'h22); send_byte(0, 8'h33);
      cs_v[0] = 1'b1;
      drive(0, 1'b1, 8'h44);
      tick();
      drive(0, 1'b0, 8'h00);
      repeat (2) tick();
      chk("csrace_ferr", n_ferr[0] - f0, 1);
      check_highs(0, "csrace");
      chk("csrace_commit", n_commit[0] - c0, 0);

      // two frames in one period: last one wins, single commit
      for (int i = 0; i < 300 && !is_wrap(0, edge_cnt - 1); i++) tick();
      c0 = n_commit[0];
      duty = '{10, 10, 10, 10};
      send_frame(0, duty, 0, le);
      tick();
      duty = '{200, 200, 200, 200};
      send_frame(0, duty, 0, le);
      wait_commit(0, 2 * PER_A + 8, ce);
      chk("overwrite_commit_edge", ce, next_wrap_after(0, le));
      for (int c = 0; c < 4; c++) m_active[0][c] = m_shadow[0][c];
      measure(0, hc);
      for (int c = 0; c < 4; c++) chk($sformatf("overwrite_high_ch%0d", c), hc[c], 200);
      chk("overwrite_commit_count", n_commit[0] - c0, 1);

      // 10-bit boundary, last byte on a wrap edge
      w = next_wrap_after(1, edge_cnt - 1 + 10);
      for (int i = 0; i < 5000 && (edge_cnt - 1) < w - 5; i++) tick();
      duty = '{1023, 1, 0, 0};
      send_frame(1, duty, 0, le);
      wait_commit(1, 2 * PER_B * P_B + 8, ce);
      chk("b_wrap_commit_edge", ce, w + PER_B * P_B);
      for (int c = 0; c < 2; c++) m_active[1][c] = m_shadow[1][c];
      measure(1, hc);
      chk("b_high_ch0", hc[0], 2046);
      chk("b_high_ch1", hc[1], 2);

      for (int it = 0; it < 2; it++) begin
         duty = '{int'($urandom_range(1023, 0)), int'($urandom_range(1023, 0)), 0, 0};
         tick();
         frame_and_check(1, duty, int'($urandom_range(63, 1)), $sformatf("rand_b%0d", it));
      end
      chk("b_ferr_total", n_ferr[1], 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
